// File: rtl/lbw_pkg.sv
// lbw_pkg: shared widths and FSM state type for the sprite line-buffer writer.
package lbw_pkg;
    localparam int PIX_W        = 8;
    localparam int PIX_PER_WORD = 16;
    localparam int LB_ADDR_W    = 7;
    localparam int WORD_W       = PIX_W * PIX_PER_WORD;
    typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, DRAW = 2'd2} lbw_state_e;
endpackage

// File: rtl/lbw_rotator.sv
// lbw_rotator: rotates the 32-pixel unaligned window (and its mask) into one 16-pixel word.
module lbw_rotator
    import lbw_pkg::*;
(
    input  logic [2*WORD_W-1:0]       window,
    input  logic [2*PIX_PER_WORD-1:0] window_mask,
    input  logic [3:0]                shift,
    output logic [WORD_W-1:0]         pix,
    output logic [PIX_PER_WORD-1:0]   vld
);
    // Modulo-32 wrap lets pixels left of the shift pull from the previous word's tail.
    for (genvar j = 0; j < PIX_PER_WORD; j++) begin : g_pix
        logic [4:0] k;
        assign k = 5'(j) - {1'b0, shift};
        assign pix[PIX_W*j +: PIX_W] = window[{k, 3'b000} +: PIX_W];
        assign vld[j] = window_mask[k];
    end
endmodule

// File: rtl/line_buffer_writer.sv
// line_buffer_writer: aligns quadrupler output, resolves sprite priority and writes the back line buffer.
// Optional LBW_COLLISION_EN adds sticky collision / collision_addr outputs.
module line_buffer_writer
    import lbw_pkg::*;
#(
    parameter int LB_WORDS       = 80,
    parameter bit PRIORITY_FIRST = 1'b1
) (
    input  logic                    clk_draw,
    input  logic                    rst_draw_n,
    input  logic                    line_start,
    input  logic [PIX_W-1:0]        bg_color,
    input  logic [LB_ADDR_W-1:0]    lb_addr,
    input  logic [2*WORD_W-1:0]     unaligned_pixels,
    input  logic [31:0]             unaligned_valid_mask,
    input  logic [3:0]              alignment_shift,
    output logic                    busy,
    output logic                    overrun,
    output logic                    lbw_we,
    output logic [LB_ADDR_W-1:0]    lbw_addr,
    output logic [WORD_W-1:0]       lbw_data,
    output logic [PIX_PER_WORD-1:0] lbw_be
`ifdef LBW_COLLISION_EN
    ,
    output logic                    collision,
    output logic [LB_ADDR_W-1:0]    collision_addr
`endif
);
    lbw_state_e                state;
    logic [LB_ADDR_W-1:0]      cnt;
    logic [PIX_W-1:0]          bg;
    logic                      s1_v;
    logic [LB_ADDR_W-1:0]      s1_addr;
    logic [WORD_W-1:0]         s1_pix;
    logic [PIX_PER_WORD-1:0]   s1_vld;
    logic [WORD_W-1:0]         rot_pix;
    logic [PIX_PER_WORD-1:0]   rot_vld;
    logic [PIX_PER_WORD-1:0]   occ [LB_WORDS];
    logic [PIX_PER_WORD-1:0]   occ_row;
    logic [PIX_PER_WORD-1:0]   eff;
    logic                      in_range;
    logic                      do_wr;

    lbw_rotator u_rot (
        .window      (unaligned_pixels),
        .window_mask (unaligned_valid_mask),
        .shift       (alignment_shift),
        .pix         (rot_pix),
        .vld         (rot_vld)
    );

    assign busy     = state == CLEAR || line_start;
    assign in_range = 32'(s1_addr) < LB_WORDS;
    assign occ_row  = in_range ? occ[s1_addr] : '0;
    assign eff      = PRIORITY_FIRST ? s1_vld & ~occ_row : s1_vld;
    // A line_start in the write cycle discards whatever stage 1 was holding.
    assign do_wr    = s1_v && in_range && !line_start && state != CLEAR && |eff;

    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bg       <= '0;
            s1_v     <= 1'b0;
            s1_addr  <= '0;
            s1_pix   <= '0;
            s1_vld   <= '0;
            overrun  <= 1'b0;
            lbw_we   <= 1'b0;
            lbw_addr <= '0;
            lbw_data <= '0;
            lbw_be   <= '0;
            for (int i = 0; i < LB_WORDS; i++) occ[i] <= '0;
        end else begin
            s1_v    <= !busy;
            s1_addr <= lb_addr;
            s1_pix  <= rot_pix;
            s1_vld  <= rot_vld;
            overrun <= (line_start ? 1'b0 : overrun) | (busy && |unaligned_valid_mask);
            if (line_start) begin
                state  <= CLEAR;
                cnt    <= '0;
                bg     <= bg_color;
                lbw_we <= 1'b0;
                lbw_be <= '0;
            end else if (state == CLEAR) begin
                lbw_we   <= 1'b1;
                lbw_addr <= cnt;
                lbw_data <= {PIX_PER_WORD{bg}};
                lbw_be   <= '1;
                occ[cnt] <= '0;
                cnt      <= cnt + 1'b1;
                if (32'(cnt) == LB_WORDS - 1) state <= DRAW;
            end else begin
                lbw_we <= do_wr;
                lbw_be <= do_wr ? eff : '0;
                if (do_wr) begin
                    lbw_addr     <= s1_addr;
                    lbw_data     <= s1_pix;
                    occ[s1_addr] <= occ_row | eff;
                end
            end
        end
    end

`ifdef LBW_COLLISION_EN
    always_ff @(posedge clk_draw or negedge rst_draw_n) begin
        if (!rst_draw_n) begin
            collision      <= 1'b0;
            collision_addr <= '0;
        end else if (line_start) begin
            collision      <= 1'b0;
        end else if (!collision && s1_v && in_range && state == DRAW && |(s1_vld & occ_row)) begin
            collision      <= 1'b1;
            collision_addr <= s1_addr;
        end
    end
`endif
endmodule

// File: tb/tb_line_buffer_writer.sv
// tb_line_buffer_writer: table vectors, directed corner sequences and a randomized run against a reference model.
module tb_line_buffer_writer;
    localparam logic [127:0] NEXT_A = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
    localparam logic [127:0] NEXT_5 = 128'h5F5E5D5C5B5A59585756555453525150;
    localparam logic [127:0] NEXT_6 = 128'h6F6E6D6C6B6A69686766656463626160;
    localparam logic [127:0] NEXT_1 = 128'h101F1E1D1C1B1A191817161514131211;

    logic         clk_draw = 1'b0;
    logic         rst_draw_n = 1'b0;
    logic         line_start = 1'b0;
    logic [7:0]   bg_color = '0;
    logic [6:0]   lb_addr = '0;
    logic [255:0] unaligned_pixels = '0;
    logic [31:0]  unaligned_valid_mask = '0;
    logic [3:0]   alignment_shift = '0;
    logic         busy, overrun, lbw_we;
    logic [6:0]   lbw_addr;
    logic [127:0] lbw_data;
    logic [15:0]  lbw_be;
`ifdef LBW_COLLISION_EN
    logic         collision;
    logic [6:0]   collision_addr;
`endif

    line_buffer_writer dut (
        .clk_draw             (clk_draw),
        .rst_draw_n           (rst_draw_n),
        .line_start           (line_start),
        .bg_color             (bg_color),
        .lb_addr              (lb_addr),
        .unaligned_pixels     (unaligned_pixels),
        .unaligned_valid_mask (unaligned_valid_mask),
        .alignment_shift      (alignment_shift),
        .busy                 (busy),
        .overrun              (overrun),
        .lbw_we               (lbw_we),
        .lbw_addr             (lbw_addr),
        .lbw_data             (lbw_data),
        .lbw_be               (lbw_be)
`ifdef LBW_COLLISION_EN
        ,
        .collision            (collision),
        .collision_addr       (collision_addr)
`endif
    );

    always #5 clk_draw = ~clk_draw;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic         we;
        logic [6:0]   addr;
        logic [15:0]  be;
        logic [127:0] data;
    } exp_t;

    typedef struct {
        logic [6:0]   addr;
        logic [3:0]   s;
        logic [255:0] pix;
        logic [31:0]  mask;
        logic         we;
        logic [15:0]  be;
        logic [127:0] data;
    } vec_t;

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] m_occ [80];
    logic [7:0]  m_lb [80][16];
    logic [7:0]  d_lb [80][16];
    vec_t        tbl [9];
    exp_t        q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_draw);
        #1;
    endtask

    function automatic logic [127:0] be_mask(input logic [15:0] be);
        logic [127:0] m;
        for (int j = 0; j < 16; j++) m[8*j +: 8] = {8{be[j]}};
        return m;
    endfunction

    task automatic check_out(input string tag, input exp_t e);
        check({tag, " we"}, 128'(lbw_we), 128'(e.we));
        if (e.we) begin
            check({tag, " addr"}, 128'(lbw_addr), 128'(e.addr));
            check({tag, " be"}, 128'(lbw_be), 128'(e.be));
            check({tag, " data"}, lbw_data & be_mask(e.be), e.data & be_mask(e.be));
        end
    endtask

    task automatic drive(input logic [6:0] a, input logic [3:0] s, input logic [255:0] w, input logic [31:0] m);
        lb_addr = a;
        alignment_shift = s;
        unaligned_pixels = w;
        unaligned_valid_mask = m;
    endtask

    // Reference: pixel j lands s slots right of its source; slots left of s come from the previous word's tail.
    function automatic exp_t model(input logic [6:0] a, input logic [3:0] s, input logic [255:0] w, input logic [31:0] m);
        exp_t e;
        logic [15:0] vld, eff;
        logic [127:0] d;
        int src;
        for (int j = 0; j < 16; j++) begin
            src = (j >= int'(s)) ? j - int'(s) : 16 + (16 + j - int'(s));
            d[8*j +: 8] = w[8*src +: 8];
            vld[j] = m[src];
        end
        e = '{1'b0, a, 16'h0, d};
        if (int'(a) < 80) begin
            eff = vld & ~m_occ[a];
            e.we = |eff;
            e.be = eff;
            m_occ[a] = m_occ[a] | eff;
            for (int j = 0; j < 16; j++) if (eff[j]) m_lb[a][j] = d[8*j +: 8];
        end
        return e;
    endfunction

    task automatic do_clear(input logic [7:0] bg);
        int nw, nb, bad;
        nw = 0; nb = 0; bad = 0;
        unaligned_valid_mask = '0;
        bg_color = bg;
        line_start = 1'b1;
        #1;
        check("busy on line_start", 128'(busy), 128'(1));
        step();
        line_start = 1'b0;
        for (int c = 0; c < 120; c++) begin
            if (busy) nb++;
            if (lbw_we) begin
                if (int'(lbw_addr) != nw || lbw_data !== {16{bg}} || lbw_be !== 16'hFFFF) bad++;
                nw++;
            end
            step();
        end
        check("clear write count", 128'(nw), 128'(80));
        check("clear busy cycles", 128'(nb), 128'(80));
        check("clear word contents", 128'(bad), 128'(0));
        for (int a = 0; a < 80; a++) begin
            m_occ[a] = '0;
            for (int j = 0; j < 16; j++) begin
                m_lb[a][j] = bg;
                d_lb[a][j] = bg;
            end
        end
    endtask

    initial begin
        int bad, nw, first_addr;
        exp_t e;
        tbl[0] = '{7'd5,  4'd0,  {128'h0, NEXT_1}, 32'h0000FFFF, 1'b1, 16'hFFFF, NEXT_1};
        tbl[1] = '{7'd10, 4'd4,  {128'h0, NEXT_A}, 32'h0000FFFF, 1'b1, 16'hFFF0, 128'hABAAA9A8A7A6A5A4A3A2A1A000000000};
        tbl[2] = '{7'd11, 4'd4,  {NEXT_A, 128'h0}, 32'hFFFF0000, 1'b1, 16'h000F, 128'hAFAEADAC};
        tbl[3] = '{7'd20, 4'd0,  {128'h0, NEXT_5}, 32'h000000FF, 1'b1, 16'h00FF, 128'h5756555453525150};
        tbl[4] = '{7'd20, 4'd0,  {128'h0, NEXT_6}, 32'h0000FFFF, 1'b1, 16'hFF00, 128'h6F6E6D6C6B6A69680000000000000000};
        tbl[5] = '{7'd80, 4'd0,  {128'h0, NEXT_6}, 32'h0000FFFF, 1'b0, 16'h0000, 128'h0};
        tbl[6] = '{7'd5,  4'd0,  {128'h0, NEXT_6}, 32'h00000001, 1'b0, 16'h0000, 128'h0};
        tbl[7] = '{7'd30, 4'd3,  {NEXT_5, NEXT_6}, 32'h00000000, 1'b0, 16'h0000, 128'h0};
        tbl[8] = '{7'd79, 4'd15, {NEXT_5, NEXT_6}, 32'hFFFFFFFF, 1'b1, 16'hFFFF, 128'h605F5E5D5C5B5A595857565554535251};

        step();
        step();
        check("reset we", 128'(lbw_we), 128'(0));
        check("reset busy", 128'(busy), 128'(0));
        check("reset outputs", {lbw_be, lbw_addr, overrun}, 128'(0));
        check("reset data", lbw_data, 128'(0));
        rst_draw_n = 1'b1;
        step();

        // IDLE writes are accepted with occupancy active.
        drive(7'd2, 4'd0, {128'h0, NEXT_5}, 32'h0000FFFF);
        step();
        drive(7'd0, 4'd0, '0, '0);
        step();
        check_out("idle write", '{1'b1, 7'd2, 16'hFFFF, NEXT_5});
        step();
        check("idle write single", 128'(lbw_we), 128'(0));

        do_clear(8'h2A);

        for (int i = 0; i < 11; i++) begin
            if (i < 9) begin
                drive(tbl[i].addr, tbl[i].s, tbl[i].pix, tbl[i].mask);
                q.push_back('{tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].data});
            end else begin
                drive(7'd0, 4'd0, '0, '0);
                q.push_back('{1'b0, 7'd0, 16'h0, 128'h0});
            end
            step();
            if (q.size() == 2) check_out($sformatf("vec%0d", i - 1), q.pop_front());
        end
        q.delete();
`ifdef LBW_COLLISION_EN
        check("collision flag", 128'(collision), 128'(1));
        check("collision addr", 128'(collision_addr), 128'(20));
`endif

        do_clear(8'h5A);
        for (int i = 0; i < 402; i++) begin
            logic [6:0] a;
            logic [31:0] m;
            logic [3:0] s;
            logic [255:0] w;
            a = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 127));
            m = ($urandom_range(0, 7) == 0 || i >= 400) ? 32'h0 : ($urandom & $urandom);
            s = 4'($urandom_range(0, 15));
            w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            drive(a, s, w, m);
            q.push_back(model(a, s, w, m));
            step();
            if (lbw_we) for (int j = 0; j < 16; j++) if (lbw_be[j]) d_lb[lbw_addr][j] = lbw_data[8*j +: 8];
            if (q.size() == 2) begin
                e = q.pop_front();
                check_out($sformatf("rand%0d", i - 1), e);
            end
        end
        q.delete();
        for (int a = 0; a < 80; a++) begin
            logic [127:0] mw, dw;
            for (int j = 0; j < 16; j++) begin
                mw[8*j +: 8] = m_lb[a][j];
                dw[8*j +: 8] = d_lb[a][j];
            end
            check($sformatf("line image word %0d", a), dw, mw);
        end

        // In-flight stage-1 data is dropped by line_start; nonzero mask while clearing raises overrun.
        do_clear(8'h3C);
        check("overrun before", 128'(overrun), 128'(0));
        drive(7'd3, 4'd0, {128'h0, NEXT_6}, 32'h0000FFFF);
        step();
        drive(7'd0, 4'd0, '0, '0);
        bg_color = 8'h77;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        check("discard in-flight", 128'(lbw_we), 128'(0));
        drive(7'd40, 4'd0, {128'h0, NEXT_6}, 32'h00000001);
        #1;
        check("busy in clear", 128'(busy), 128'(1));
        step();
        drive(7'd0, 4'd0, '0, '0);
        check("overrun set", 128'(overrun), 128'(1));
        bad = 0; nw = 0;
        for (int c = 0; c < 100; c++) begin
            if (lbw_we) begin
                if (int'(lbw_addr) != nw || lbw_be !== 16'hFFFF || lbw_data !== {16{8'h77}}) bad++;
                nw++;
            end
            step();
        end
        check("overrun clear writes", 128'(nw), 128'(80));
        check("overrun dropped draw", 128'(bad), 128'(0));
        check("overrun sticky", 128'(overrun), 128'(1));
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        check("overrun cleared", 128'(overrun), 128'(0));

        // Restart mid-clear, then async reset with the clear counter at 37.
        for (int c = 0; c < 100 && !(lbw_we && lbw_addr == 7'd10); c++) step();
        check("reached word 10", 128'(lbw_addr), 128'(10));
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        check("restart gap", 128'(lbw_we), 128'(0));
        step();
        check("restart at 0 we", 128'(lbw_we), 128'(1));
        check("restart at 0 addr", 128'(lbw_addr), 128'(0));
        first_addr = -1;
        for (int c = 0; c < 100; c++) begin
            if (lbw_we && lbw_addr == 7'd36) begin
                first_addr = 36;
                break;
            end
            step();
        end
        check("reached counter 37", 128'(first_addr), 128'(36));
        rst_draw_n = 1'b0;
        step();
        check("reset mid-clear we", 128'(lbw_we), 128'(0));
        check("reset mid-clear busy", 128'(busy), 128'(0));
        check("reset mid-clear outs", {lbw_be, lbw_addr, overrun}, 128'(0));
        rst_draw_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (lbw_we || busy) bad++;
        end
        check("no writes after reset", 128'(bad), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
